ldc_series: RTL and testbench
=============================

LDC_SERIES -- requirements
Module: ldc_series

Interface
REQ-001 Parameter WIDTH, default 16: signed two's-complement data width of x, v, distance.
REQ-002 Parameter FRAC, default 8: fractional bits of the fixed-point format; legal range 1 to WIDTH-2.
REQ-003 Parameter TERMS, default 6: number of series terms; legal range 2 to 8.
REQ-004 Parameter TAG_W, default 2: channel tag width.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  operand request.
REQ-008 in_ready  output  1  block idle and able to accept a request.
REQ-009 x  input  WIDTH  signed base operand.
REQ-010 v  input  WIDTH  signed exponent operand.
REQ-011 in_tag  input  TAG_W  channel identifier, returned with the result.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 distance  output  WIDTH  signed result.
REQ-015 out_tag  output  TAG_W  tag of the request that produced distance.
REQ-016 overflow  output  1  result was clamped (see Configuration).

Function
REQ-017 The block SHALL compute distance = sum over k=0..TERMS-1 of x*v^k/k!, in fixed point with FRAC fractional bits.
REQ-018 States SHALL be IDLE, MULV, SCALE and OUT; in_ready SHALL equal (state==IDLE).
REQ-019 When in_valid and in_ready are both high at an edge, the block SHALL capture v and in_tag, set term=x, acc=x, k=1, clear overflow, and go to MULV.
REQ-020 In MULV, the block SHALL set term = (term*v) >>> FRAC and go to SCALE.
REQ-021 In SCALE, the block SHALL set term = (term*R[k]) >>> FRAC, where R[k] = floor(2^FRAC/k) is a constant table.
- Same edge: acc = acc + new term.
- If k==TERMS-1, go to OUT; otherwise increment k and go to MULV.
REQ-022 All products SHALL be full 2*WIDTH-bit signed products, followed by an arithmetic shift right (floor) and reduction to WIDTH bits.
REQ-023 Latency: out_valid SHALL rise exactly 2*(TERMS-1) edges after the accept edge (10 for the defaults).
REQ-024 In OUT, out_valid SHALL be 1, and distance = acc, out_tag and overflow SHALL be held stable until out_ready is high.
REQ-025 On the edge with out_valid and out_ready both high, the block SHALL go to IDLE; in_ready rises the following cycle.
REQ-026 in_valid SHALL be ignored while not in IDLE; operand inputs SHALL not be sampled after the accept edge.
REQ-027 Throughput: one result per 2*TERMS edges at most, with out_ready held high.

Reset
REQ-028 rst low SHALL immediately force state=IDLE, in_ready=1, out_valid=0, distance=0, out_tag=0, overflow=0, and term, acc and k to 0, irrespective of clk.
REQ-029 Reset asserted mid-computation SHALL discard the request with no result produced; the first accept after release SHALL behave as from power-up.

Configuration
REQ-030 Macro LDC_SATURATE_EN.
- When defined: every product reduction and every accumulate SHALL clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1], and any clamp during a request SHALL set overflow, held until the next accept.
- When undefined: results SHALL wrap modulo 2^WIDTH, and overflow SHALL be tied to 0.

Verification
REQ-031 Defaults; x=0x0100, v=0x0000, tag=1 -> out_valid 10 edges after accept, distance=0x0100, out_tag=1, overflow=0.
REQ-032 Defaults; x=0x0100, v=0x0100 -> distance=0x02B5 (693).
REQ-033 Defaults; x=0x0100, v=0xFF00 -> distance=0x005D (93), exercising floor rounding of negative terms.
REQ-034 Defaults, LDC_SATURATE_EN defined; x=0x7F00, v=0x0400 -> distance=0x7FFF, overflow=1. Same stimulus with the macro undefined -> overflow=0.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles after out_valid rises, pulse in_valid with new operands meanwhile -> result and out_tag stable, second request not accepted until one cycle after the out handshake.
REQ-036 Assert rst low 4 edges after an accept -> out_valid=0 and in_ready=1 immediately; a subsequent request x=0x0100, v=0 -> distance=0x0100.

Source files
------------

// File: rtl/ldc_series.sv
// Sequential fixed-point series evaluator: distance = sum_{k<TERMS} x*v^k/k!.
// Build option: define LDC_SATURATE_EN to clamp every reduction/accumulate and report overflow.
module ldc_series #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int TERMS = 6,
    parameter int TAG_W = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] v,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] distance,
    output logic [TAG_W-1:0]        out_tag,
    output logic                    overflow
);

    localparam int K_W = $clog2(TERMS);
    localparam int R_N = 1 << K_W;
    localparam int ONE = 1 << FRAC;

`ifdef LDC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, MULV, SCALE, OUT} state_t;

    typedef struct packed {
        logic signed [WIDTH-1:0] v;
        logic [TAG_W-1:0]        tag;
    } req_t;

    state_t                    state;
    req_t                      req_q;
    logic signed [WIDTH-1:0]   term;
    logic signed [WIDTH-1:0]   acc;
    logic [K_W-1:0]            k;

    logic signed [WIDTH-1:0]   rtab [R_N];
    logic signed [WIDTH-1:0]   mul_b;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [2*WIDTH-1:0] shf;
    logic signed [WIDTH-1:0]   red_val;
    logic                      red_ovf;
    logic signed [WIDTH:0]     sum;
    logic signed [WIDTH-1:0]   sum_val;
    logic                      sum_ovf;

    // Reciprocal table R[k] = floor(2^FRAC / k); unused slots are zero.
    for (genvar i = 0; i < R_N; i++) begin : g_rtab
        if (i == 0 || i >= TERMS) begin : g_zero
            assign rtab[i] = '0;
        end else begin : g_rec
            assign rtab[i] = WIDTH'(ONE / i);
        end
    end

    assign in_ready = (state == IDLE);

    // One shared multiplier: by v in MULV, by R[k] in SCALE.
    always_comb begin
        mul_b   = (state == MULV) ? req_q.v : rtab[k];
        prod    = term * mul_b;
        shf     = prod >>> FRAC;
        red_ovf = SAT && (shf[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){shf[2*WIDTH-1]}});
        red_val = red_ovf ? {shf[2*WIDTH-1], {(WIDTH-1){~shf[2*WIDTH-1]}}}
                          : shf[WIDTH-1:0];
        sum     = {acc[WIDTH-1], acc} + {red_val[WIDTH-1], red_val};
        sum_ovf = SAT && (sum[WIDTH] != sum[WIDTH-1]);
        sum_val = sum_ovf ? {sum[WIDTH], {(WIDTH-1){~sum[WIDTH]}}}
                          : sum[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            req_q     <= '0;
            term      <= '0;
            acc       <= '0;
            k         <= '0;
            out_valid <= 1'b0;
            distance  <= '0;
            out_tag   <= '0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        req_q.v   <= v;
                        req_q.tag <= in_tag;
                        term      <= x;
                        acc       <= x;
                        k         <= K_W'(1);
                        overflow  <= 1'b0;
                        state     <= MULV;
                    end
                end
                MULV: begin
                    term     <= red_val;
                    overflow <= overflow | red_ovf;
                    state    <= SCALE;
                end
                SCALE: begin
                    term     <= red_val;
                    acc      <= sum_val;
                    overflow <= overflow | red_ovf | sum_ovf;
                    if (k == K_W'(TERMS - 1)) begin
                        distance  <= sum_val;
                        out_tag   <= req_q.tag;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        k     <= k + 1'b1;
                        state <= MULV;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ldc_series.sv
// Directed bench for ldc_series at default parameters, hand-computed expectations.
module tb_ldc_series;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] x;
    logic signed [15:0] v;
    logic [1:0]         in_tag;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] distance;
    logic [1:0]         out_tag;
    logic               overflow;

    int n_chk = 0;
    int n_err = 0;

    ldc_series dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .v(v), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .distance(distance), .out_tag(out_tag), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Counts edges after the accept edge until out_valid is seen (bounded).
    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 40);
    endtask

    // Accept a request, scramble the operand inputs afterwards, check result and handshake.
    task automatic run(input string name, input logic [15:0] xi, input logic [15:0] vi,
                       input logic [1:0] ti, input logic [15:0] exp_d, input logic chk_d,
                       input logic exp_ovf);
        int lat;
        @(negedge clk);
        chk({name, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; x = xi; v = vi; in_tag = ti;
        @(posedge clk);
        #1;
        in_valid = 1'b0; x = 16'h5A5A; v = 16'h1234; in_tag = ~ti;
        wait_out(lat);
        chk({name, ".latency"}, 32'(lat), 32'd10);
        if (chk_d) chk({name, ".distance"}, 32'(distance), 32'(exp_d));
        chk({name, ".out_tag"}, 32'(out_tag), 32'(ti));
        chk({name, ".overflow"}, 32'(overflow), 32'(exp_ovf));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({name, ".out_valid_drop"}, 32'(out_valid), 32'd0);
        chk({name, ".in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        x = '0; v = '0; in_tag = '0;
        #12;
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.distance", 32'(distance), 32'd0);
        chk("rst.out_tag", 32'(out_tag), 32'd0);
        chk("rst.overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        run("v0", 16'h0100, 16'h0000, 2'd1, 16'h0100, 1'b1, 1'b0);
        run("v1", 16'h0100, 16'h0100, 2'd2, 16'h02B5, 1'b1, 1'b0);
        run("vneg", 16'h0100, 16'hFF00, 2'd3, 16'h005D, 1'b1, 1'b0);
`ifdef LDC_SATURATE_EN
        run("sat", 16'h7F00, 16'h0400, 2'd0, 16'h7FFF, 1'b1, 1'b1);
`else
        run("sat", 16'h7F00, 16'h0400, 2'd0, 16'h0000, 1'b0, 1'b0);
`endif

        // Backpressure: hold the result while a second request is offered.
        @(negedge clk);
        in_valid = 1'b1; x = 16'h0100; v = 16'h0100; in_tag = 2'd2;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_out(lat);
        chk("bp.latency", 32'(lat), 32'd10);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; x = 16'h0100; v = 16'hFF00; in_tag = 2'd3;
            chk("bp.hold_distance", 32'(distance), 32'h02B5);
            chk("bp.hold_tag", 32'(out_tag), 32'd2);
            chk("bp.hold_valid", 32'(out_valid), 32'd1);
            chk("bp.in_ready_low", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        chk("bp.in_ready_at_hs", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp.in_ready_after_hs", 32'(in_ready), 32'd1);
        chk("bp.out_valid_after_hs", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp.second_accepted", 32'(in_ready), 32'd0);
        wait_out(lat);
        chk("bp2.latency", 32'(lat), 32'd10);
        chk("bp2.distance", 32'(distance), 32'h005D);
        chk("bp2.out_tag", 32'(out_tag), 32'd3);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset mid-computation discards the request.
        @(negedge clk);
        in_valid = 1'b1; x = 16'h0100; v = 16'h0100; in_tag = 2'd2;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("mid.out_valid", 32'(out_valid), 32'd0);
        chk("mid.in_ready", 32'(in_ready), 32'd1);
        chk("mid.distance", 32'(distance), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("mid.no_result", 32'(out_valid), 32'd0);
        run("post", 16'h0100, 16'h0000, 2'd1, 16'h0100, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
